// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-select encodings, opcodes and fetch FSM states.
package cpu_pkg;

   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned OP_W       = 6;
   localparam int unsigned WAIT_CNT_W = 8;

   typedef enum logic [1:0] {
      PC_SEQ = 2'b00,
      PC_BR  = 2'b01,
      PC_JR  = 2'b10,
      PC_J   = 2'b11
   } pc_src_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_WAIT  = 3'd1,
      ST_RETRY = 3'd2,
      ST_HOLD  = 3'd3,
      ST_HALT  = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: sequential, PC-relative branch, register jump, absolute jump.
module next_pc_calc
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [25:0]       imm_field,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic [1:0]        pc_src,
   output logic [ADDR_W-1:0] next_pc,
   output logic [ADDR_W-1:0] pc_plus4
);

   logic [ADDR_W-1:0] br_off;

   assign pc_plus4 = pc + ADDR_W'(4);
   assign br_off   = {{(ADDR_W-18){imm_field[15]}}, imm_field[15:0], 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      case (pc_src)
         PC_SEQ:  next_pc = pc_plus4;
         PC_BR:   next_pc = pc_plus4 + br_off;
         PC_JR:   next_pc = jr_target;
         PC_J:    next_pc = {pc_plus4[ADDR_W-1:28], imm_field, 2'b00};
         default: next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC/IR ownership and imem req/ack handshake with timeout retry.
// Optional alignment trap on PC loads enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       MAX_WAIT = 15
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              PCWre,
   input  logic [1:0]        PCSrc,
   input  logic [ADDR_W-1:0] jr_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [31:0]       ir,
   output logic [5:0]        op,
   output logic              ir_valid,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic              align_fault,
`endif
   output logic              halted
);

   fetch_state_e            state, state_next;
   logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_d;
   logic [ADDR_W-1:0]       pc_d, next_pc_raw, load_pc;
   logic [31:0]             ir_d;
   logic                    ir_valid_d, halted_d, req_d;
   logic                    is_halt, timeout, misaligned;

   next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
      .pc        (pc),
      .imm_field (ir[25:0]),
      .jr_target (jr_target),
      .pc_src    (PCSrc),
      .next_pc   (next_pc_raw),
      .pc_plus4  (pc_plus4)
   );

   assign is_halt   = (ir[31:26] == OP_HALT);
   assign timeout   = (wait_cnt == WAIT_CNT_W'(MAX_WAIT - 1));
   assign op        = ir[31:26];
   assign imem_addr = pc;

`ifdef FETCH_ALIGN_CHECK_EN
   logic align_fault_d;
   assign misaligned = (next_pc_raw[1:0] != 2'b00);
   assign load_pc    = next_pc_raw;
`else
   assign misaligned = 1'b0;
   assign load_pc    = next_pc_raw & ~ADDR_W'(3);
`endif

   // All sequential state, including the datapath registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= ST_FETCH;
         pc       <= RESET_PC;
         ir       <= '0;
         ir_valid <= 1'b0;
         imem_req <= 1'b0;
         halted   <= 1'b0;
         wait_cnt <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
         align_fault <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         pc       <= pc_d;
         ir       <= ir_d;
         ir_valid <= ir_valid_d;
         imem_req <= req_d;
         halted   <= halted_d;
         wait_cnt <= wait_cnt_d;
`ifdef FETCH_ALIGN_CHECK_EN
         align_fault <= align_fault_d;
`endif
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_FETCH: state_next = ST_WAIT;
         ST_WAIT: begin
            if (imem_ack)     state_next = ST_HOLD;
            else if (timeout) state_next = ST_RETRY;
         end
         ST_RETRY: state_next = ST_FETCH;
         ST_HOLD: begin
            if (is_halt)    state_next = ST_HALT;
            else if (PCWre) state_next = misaligned ? ST_HALT : ST_FETCH;
         end
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_FETCH;
      endcase
   end

   // Request is high through FETCH and WAIT so a retry shows exactly one low cycle.
   always_comb begin
      pc_d       = pc;
      ir_d       = ir;
      ir_valid_d = ir_valid;
      halted_d   = halted;
      wait_cnt_d = wait_cnt;
      req_d      = (state_next == ST_FETCH) || (state_next == ST_WAIT);
`ifdef FETCH_ALIGN_CHECK_EN
      align_fault_d = align_fault;
`endif
      case (state)
         ST_FETCH: wait_cnt_d = '0;
         ST_WAIT: begin
            if (imem_ack) begin
               ir_d       = imem_rdata;
               ir_valid_d = 1'b1;
            end else if (!timeout) begin
               wait_cnt_d = wait_cnt + WAIT_CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (is_halt) begin
               halted_d = 1'b1;
            end else if (PCWre) begin
               if (misaligned) begin
                  halted_d = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                  align_fault_d = 1'b1;
`endif
               end else begin
                  pc_d       = load_pc;
                  ir_valid_d = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: PC-select vectors plus retry, halt and reset sequences.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned MAX_WAIT = 15;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              PCWre = 1'b0;
   logic [1:0]        PCSrc = 2'b00;
   logic [ADDR_W-1:0] jr_target = '0;
   logic              imem_ack = 1'b0;
   logic [31:0]       imem_rdata = '0;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr, pc, pc_plus4;
   logic [31:0]       ir;
   logic [5:0]        op;
   logic              ir_valid, halted;
`ifdef FETCH_ALIGN_CHECK_EN
   logic              align_fault;
`endif

   fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000), .MAX_WAIT(MAX_WAIT)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .PCWre      (PCWre),
      .PCSrc      (PCSrc),
      .jr_target  (jr_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .ir         (ir),
      .op         (op),
      .ir_valid   (ir_valid),
`ifdef FETCH_ALIGN_CHECK_EN
      .align_fault(align_fault),
`endif
      .halted     (halted)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!imem_req && n < 64) begin
         tick();
         n++;
      end
      chk({name, " req_seen"}, 64'(imem_req), 64'd1);
   endtask

   task automatic deliver(input string name, input logic [31:0] word, input int unsigned dly);
      repeat (dly) tick();
      chk({name, " ir_valid_before_ack"}, 64'(ir_valid), 64'd0);
      imem_rdata = word;
      imem_ack   = 1'b1;
      tick();
      imem_ack   = 1'b0;
   endtask

   typedef struct {
      logic [31:0]  instr;
      int unsigned  ack_dly;
      logic [1:0]   src;
      logic [31:0]  jr;
      logic [31:0]  exp_addr;
      logic [31:0]  exp_next;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      vecs[0] = '{32'h0800_0004, 2, PC_J,   32'h0,         32'h0000_0000, 32'h0000_0010};
      vecs[1] = '{32'h1000_FFFF, 1, PC_BR,  32'h0,         32'h0000_0010, 32'h0000_0010};
      vecs[2] = '{32'h1000_FFFF, 3, PC_SEQ, 32'h0,         32'h0000_0010, 32'h0000_0014};
      vecs[3] = '{32'h0000_0008, 2, PC_JR,  32'h1000_0000, 32'h0000_0014, 32'h1000_0000};
      vecs[4] = '{32'h0800_0040, 1, PC_J,   32'h0,         32'h1000_0000, 32'h1000_0100};
      vecs[5] = '{32'h0000_0008, 3, PC_JR,  32'h0000_0080, 32'h1000_0100, 32'h0000_0080};

      // Reset state
      repeat (2) tick();
      chk("rst imem_req", 64'(imem_req), 64'd0);
      chk("rst pc", 64'(pc), 64'h0);
      chk("rst ir", 64'(ir), 64'h0);
      chk("rst ir_valid", 64'(ir_valid), 64'd0);
      chk("rst halted", 64'(halted), 64'd0);
      chk("rst pc_plus4", 64'(pc_plus4), 64'h4);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("rst align_fault", 64'(align_fault), 64'd0);
`endif
      RST = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         wait_req(nm);
         chk({nm, " imem_addr"}, 64'(imem_addr), 64'(vecs[i].exp_addr));
         deliver(nm, vecs[i].instr, vecs[i].ack_dly);
         chk({nm, " ir_valid"}, 64'(ir_valid), 64'd1);
         chk({nm, " ir"}, 64'(ir), 64'(vecs[i].instr));
         chk({nm, " op"}, 64'(op), 64'(vecs[i].instr[31:26]));
         chk({nm, " req_low"}, 64'(imem_req), 64'd0);
         chk({nm, " pc_hold"}, 64'(pc), 64'(vecs[i].exp_addr));
         chk({nm, " pc_plus4"}, 64'(pc_plus4), 64'(vecs[i].exp_addr + 32'd4));
         PCSrc     = vecs[i].src;
         jr_target = vecs[i].jr;
         PCWre     = 1'b1;
         tick();
         PCWre     = 1'b0;
         chk({nm, " next_pc"}, 64'(pc), 64'(vecs[i].exp_next));
         chk({nm, " ir_valid_clr"}, 64'(ir_valid), 64'd0);
         chk({nm, " req_refetch"}, 64'(imem_req), 64'd1);
      end

      // Timeout: req high through FETCH + MAX_WAIT WAIT cycles, then one low cycle
      begin
         int hi = 0;
         int lo = 0;
         while (imem_req && hi < 64) begin
            hi++;
            PCSrc = PC_SEQ;
            PCWre = (hi == 5);
            tick();
         end
         PCWre = 1'b0;
         chk("timeout req_high_cycles", 64'(hi), 64'(MAX_WAIT + 1));
         chk("pcwre_in_wait pc", 64'(pc), 64'h80);
         while (!imem_req && lo < 64) begin
            lo++;
            tick();
         end
         chk("retry req_low_cycles", 64'(lo), 64'd1);
         chk("retry imem_addr", 64'(imem_addr), 64'h80);
      end

      // Ack on the timeout cycle of the second attempt is accepted; halt opcode
      repeat (MAX_WAIT) tick();
      imem_rdata = 32'hFC00_0000;
      imem_ack   = 1'b1;
      tick();
      imem_ack   = 1'b0;
      chk("ack_at_timeout ir_valid", 64'(ir_valid), 64'd1);
      chk("ack_at_timeout ir", 64'(ir), 64'hFC00_0000);
      chk("ack_at_timeout req", 64'(imem_req), 64'd0);
      tick();
      chk("halt halted", 64'(halted), 64'd1);
      chk("halt req", 64'(imem_req), 64'd0);
      for (int k = 0; k < 3; k++) begin
         PCSrc = PC_SEQ;
         PCWre = 1'b1;
         tick();
         PCWre = 1'b0;
         tick();
         chk($sformatf("halt pcwre%0d pc", k), 64'(pc), 64'h80);
         chk($sformatf("halt pcwre%0d req", k), 64'(imem_req), 64'd0);
      end
      imem_rdata = 32'h1234_5678;
      imem_ack   = 1'b1;
      tick();
      imem_ack   = 1'b0;
      chk("halt ack_ignored ir", 64'(ir), 64'hFC00_0000);
      chk("halt still_halted", 64'(halted), 64'd1);

      // Reset in the middle of WAIT, with an ack arriving during reset
      RST = 1'b0;
      tick();
      RST = 1'b1;
      tick();
      chk("rst2 req_wait", 64'(imem_req), 64'd1);
      tick();
      tick();
      #2;
      RST        = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      #1;
      chk("midwait_rst req", 64'(imem_req), 64'd0);
      chk("midwait_rst pc", 64'(pc), 64'h0);
      chk("midwait_rst halted", 64'(halted), 64'd0);
      tick();
      tick();
      chk("ack_in_rst ir", 64'(ir), 64'h0);
      chk("ack_in_rst ir_valid", 64'(ir_valid), 64'd0);
      imem_ack = 1'b0;
      RST      = 1'b1;
      tick();
      chk("post_rst req", 64'(imem_req), 64'd1);
      chk("post_rst addr", 64'(imem_addr), 64'h0);

      // Misaligned register-jump target
      deliver("align", 32'h0000_0008, 1);
      chk("align ir_valid", 64'(ir_valid), 64'd1);
      PCSrc     = PC_JR;
      jr_target = 32'h0000_0082;
      PCWre     = 1'b1;
      tick();
      PCWre     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("align fault", 64'(align_fault), 64'd1);
      chk("align pc_kept", 64'(pc), 64'h0);
      chk("align halted", 64'(halted), 64'd1);
      chk("align req", 64'(imem_req), 64'd0);
`else
      chk("align forced_pc", 64'(pc), 64'h80);
      chk("align not_halted", 64'(halted), 64'd0);
      chk("align req", 64'(imem_req), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
